// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM encoding and default parameters for fetch_sequencer.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2} state_t;
  localparam int DEF_ADDR_W = 2;
  localparam int DEF_INSTR_W = 8;
  localparam int DEF_PROG_LEN = 4;
  localparam int DEF_WAIT_CYCLES = 3;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: memory and consumer signals of fetch_sequencer; FETCH_SEQ_JUMP_EN adds jump_valid/jump_addr.
interface fetch_sequencer_if import fetch_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
);
  logic en;
  logic [INSTR_W-1:0] instruction;
  logic [ADDR_W-1:0] address;
  logic fetch_req;
  logic [INSTR_W-1:0] result;
  logic result_valid;
  logic result_ready;
  logic wrap;
`ifdef FETCH_SEQ_JUMP_EN
  logic jump_valid;
  logic [ADDR_W-1:0] jump_addr;
`endif
  modport master(
    input en, instruction, result_ready,
`ifdef FETCH_SEQ_JUMP_EN
    input jump_valid, jump_addr,
`endif
    output address, fetch_req, result, result_valid, wrap
  );
  modport slave(
    output en, instruction, result_ready,
`ifdef FETCH_SEQ_JUMP_EN
    output jump_valid, jump_addr,
`endif
    input address, fetch_req, result, result_valid, wrap
  );
endinterface

// File: rtl/fetch_addr_gen.sv
// fetch_addr_gen: fetch address register with increment, wrap to 0 at PROG_LEN-1, and jump load.
module fetch_addr_gen #(
  parameter int ADDR_W = 2,
  parameter int PROG_LEN = 4
) (
  input logic clk,
  input logic rst_n,
  input logic advance,
  input logic jump,
  input logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] address,
  output logic wrap
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PROG_LEN - 1);
  localparam logic [ADDR_W:0] LEN = (ADDR_W + 1)'(PROG_LEN);
  logic last;
  logic [ADDR_W-1:0] target;
  always_comb begin
    last = address == LAST;
    target = ({1'b0, jump_addr} >= LEN) ? '0 : jump_addr;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      address <= '0;
      wrap <= 1'b0;
    end else begin
      address <= jump ? target : advance ? (last ? '0 : address + 1'b1) : address;
      wrap <= !jump && advance && last;
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: IDLE/FETCH/HOLD instruction fetch with fixed read latency and result handshake.
// Define FETCH_SEQ_JUMP_EN to honour jump_valid/jump_addr in IDLE or on a handshake.
module fetch_sequencer import fetch_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int PROG_LEN = DEF_PROG_LEN,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input logic clk,
  input logic rst_n,
  fetch_sequencer_if.master bus
);
  state_t state, state_n;
  logic [7:0] count;
  logic [INSTR_W-1:0] result;
  logic [ADDR_W-1:0] address, jump_addr;
  logic result_valid, fetch_req, wrap, capture, handshake, jump;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = (state == IDLE) ? (bus.en ? FETCH : IDLE) :
              (state == FETCH) ? (count == 8'd0 ? HOLD : FETCH) :
              (state == HOLD) ? (handshake ? (bus.en ? FETCH : IDLE) : HOLD) : IDLE;
  always_comb begin
    capture = state == FETCH && count == 8'd0;
    handshake = result_valid && bus.result_ready;
  end
`ifdef FETCH_SEQ_JUMP_EN
  assign jump = bus.jump_valid && (state == IDLE || handshake);
  assign jump_addr = bus.jump_addr;
`else
  assign jump = 1'b0;
  assign jump_addr = '0;
`endif
  // counter reloads on every entry to FETCH and reads 0 on the capture cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= 8'd0;
      fetch_req <= 1'b0;
      result <= '0;
      result_valid <= 1'b0;
    end else begin
      count <= (state_n == FETCH) ? ((state == FETCH) ? count - 8'd1 : 8'(WAIT_CYCLES)) : 8'd0;
      fetch_req <= state_n == FETCH;
      result <= capture ? bus.instruction : result;
      result_valid <= capture ? 1'b1 : handshake ? 1'b0 : result_valid;
    end
  fetch_addr_gen #(.ADDR_W(ADDR_W), .PROG_LEN(PROG_LEN)) u_addr (
    .clk(clk),
    .rst_n(rst_n),
    .advance(handshake),
    .jump(jump),
    .jump_addr(jump_addr),
    .address(address),
    .wrap(wrap)
  );
  assign bus.address = address;
  assign bus.fetch_req = fetch_req;
  assign bus.result = result;
  assign bus.result_valid = result_valid;
  assign bus.wrap = wrap;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of fetch timing, wrap, hold, early en drop, reset and optional jump.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  fetch_sequencer_if #(.ADDR_W(2), .INSTR_W(8)) bus ();
  fetch_sequencer #(.ADDR_W(2), .INSTR_W(8), .PROG_LEN(4), .WAIT_CYCLES(3)) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
`ifdef FETCH_SEQ_JUMP_EN
  fetch_sequencer_if #(.ADDR_W(3), .INSTR_W(8)) bus3 ();
  fetch_sequencer #(.ADDR_W(3), .INSTR_W(8), .PROG_LEN(5), .WAIT_CYCLES(0)) u_dut3 (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus3)
  );
`endif
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int fr, first, n, wraps, wrap_bad;
    logic [1:0] addrs [5];
    logic seen;
    bus.en = 1'b0;
    bus.result_ready = 1'b0;
    bus.instruction = 8'hA5;
`ifdef FETCH_SEQ_JUMP_EN
    bus.jump_valid = 1'b0;
    bus.jump_addr = '0;
    bus3.en = 1'b0;
    bus3.result_ready = 1'b0;
    bus3.instruction = 8'h00;
    bus3.jump_valid = 1'b0;
    bus3.jump_addr = '0;
`endif
    #1;
    check("rst_address", 32'(bus.address), 0);
    check("rst_fetch_req", 32'(bus.fetch_req), 0);
    check("rst_result", 32'(bus.result), 0);
    check("rst_result_valid", 32'(bus.result_valid), 0);
    check("rst_wrap", 32'(bus.wrap), 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_fetch_req", 32'(bus.fetch_req), 0);
    // first fetch: valid 5 edges after en, fetch_req 4 cycles
    bus.en = 1'b1;
    bus.result_ready = 1'b1;
    fr = 0;
    first = 0;
    for (int i = 1; i <= 12 && first == 0; i++) begin
      tick();
      if (bus.fetch_req) fr++;
      if (bus.result_valid) first = i;
    end
    check("first_valid_cycle", 32'(first), 5);
    check("fetch_req_width", 32'(fr), 4);
    check("first_result", 32'(bus.result), 32'hA5);
    check("first_address", 32'(bus.address), 0);
    // address sequence over five handshakes
    addrs[0] = bus.address;
    n = 1;
    wraps = 0;
    wrap_bad = 0;
    for (int i = 0; i < 60 && n < 5; i++) begin
      tick();
      if (bus.wrap) begin
        wraps++;
        if (bus.address != 2'd0) wrap_bad++;
      end
      if (bus.result_valid) begin
        addrs[n] = bus.address;
        n++;
      end
    end
    bus.result_ready = 1'b0;
    check("seq_count", 32'(n), 5);
    for (int i = 0; i < 5; i++) check($sformatf("seq_addr%0d", i), 32'(addrs[i]), 32'(i % 4));
    check("wrap_pulses", 32'(wraps), 1);
    check("wrap_addr", 32'(wrap_bad), 0);
    // stall in HOLD with changing instruction
    for (int i = 0; i < 10; i++) begin
      bus.instruction = 8'(i * 17 + 1);
      tick();
    end
    check("hold_result", 32'(bus.result), 32'hA5);
    check("hold_address", 32'(bus.address), 0);
    check("hold_fetch_req", 32'(bus.fetch_req), 0);
    check("hold_valid", 32'(bus.result_valid), 1);
    // reset in the middle of the fetch at address 2
    bus.result_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = bus.fetch_req && bus.address == 2'd2;
    end
    check("reach_addr2", 32'(seen), 1);
    tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_address", 32'(bus.address), 0);
    check("async_rst_fetch_req", 32'(bus.fetch_req), 0);
    check("async_rst_result", 32'(bus.result), 0);
    check("async_rst_valid", 32'(bus.result_valid), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_fetch_req", 32'(bus.fetch_req), 1);
    check("post_rst_address", 32'(bus.address), 0);
    // en dropped on the second FETCH cycle
    bus.instruction = 8'h3C;
    bus.result_ready = 1'b0;
    tick();
    bus.en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = bus.result_valid;
    end
    check("drop_en_valid", 32'(seen), 1);
    check("drop_en_result", 32'(bus.result), 32'h3C);
    check("drop_en_address", 32'(bus.address), 0);
    bus.result_ready = 1'b1;
    tick();
    check("drop_en_hs_valid", 32'(bus.result_valid), 0);
    check("drop_en_hs_address", 32'(bus.address), 1);
    tick();
    tick();
    tick();
    check("idle_stays_fetch_req", 32'(bus.fetch_req), 0);
    check("idle_ready_address", 32'(bus.address), 1);
    check("idle_ready_valid", 32'(bus.result_valid), 0);
`ifdef FETCH_SEQ_JUMP_EN
    bus.jump_valid = 1'b1;
    bus.jump_addr = 2'd0;
    tick();
    bus.jump_valid = 1'b0;
    check("jump_idle_address", 32'(bus.address), 0);
    bus.en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = bus.result_valid;
    end
    check("jump_fetch_valid", 32'(seen), 1);
    bus.jump_valid = 1'b1;
    bus.jump_addr = 2'd3;
    tick();
    check("jump_hs_address", 32'(bus.address), 3);
    check("jump_hs_wrap", 32'(bus.wrap), 0);
    bus.jump_addr = 2'd1;
    tick();
    bus.jump_valid = 1'b0;
    check("jump_fetch_ignored", 32'(bus.address), 3);
    bus3.jump_valid = 1'b1;
    bus3.jump_addr = 3'd2;
    tick();
    check("jump3_addr2", 32'(bus3.address), 2);
    bus3.jump_addr = 3'd5;
    tick();
    bus3.jump_valid = 1'b0;
    check("jump3_oob", 32'(bus3.address), 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 2: width of the instruction address.
REQ-002 SHALL have parameter INSTR_W, default 8: width of the instruction word.
REQ-003 SHALL have parameter PROG_LEN, default 4: number of valid addresses, legal range 2..2^ADDR_W.
REQ-004 SHALL have parameter WAIT_CYCLES, default 3: memory read latency in clk cycles, legal range 0..255.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port en, input, 1 bit: run enable.
REQ-008 SHALL have port instruction, input, INSTR_W bits: read data from instruction memory.
REQ-009 SHALL have port address, output, ADDR_W bits: current fetch address, registered.
REQ-010 SHALL have port fetch_req, output, 1 bit: memory read strobe, registered.
REQ-011 SHALL have port result, output, INSTR_W bits: captured instruction, registered.
REQ-012 SHALL have port result_valid, output, 1 bit: result holds an unconsumed instruction.
REQ-013 SHALL have port result_ready, input, 1 bit: consumer accepts result.
REQ-014 SHALL have port wrap, output, 1 bit: one-cycle pulse when address wraps to 0.

Function
REQ-015 SHALL implement three states: IDLE, FETCH and HOLD.
REQ-016 IDLE: SHALL move to FETCH on the next edge when en=1; fetch_req=0.
REQ-017 FETCH: SHALL hold fetch_req=1 and address stable for exactly WAIT_CYCLES+1 cycles; a down-counter is loaded with WAIT_CYCLES on entry.
REQ-018 FETCH: SHALL sample instruction into result on the edge at which the counter is 0, set result_valid=1 on that same edge, and move to HOLD.
REQ-019 HOLD: SHALL keep result and result_valid=1 stable until result_ready=1 is sampled.
REQ-020 On the handshake (result_valid and result_ready both 1), SHALL clear result_valid, advance address, and go to FETCH if en=1, else to IDLE.
REQ-021 Address advance SHALL be address+1, or 0 when address = PROG_LEN-1; wrap SHALL be 1 for exactly the cycle following the wrap.
REQ-022 en deasserted during FETCH SHALL NOT abort the read; the fetch completes and HOLD is entered.
REQ-023 result_ready while result_valid=0 SHALL have no effect.
REQ-024 WAIT_CYCLES=0 SHALL give a fetch_req width of 1 cycle; first result_valid arrives 2 cycles after en is first sampled high.

Reset
REQ-025 rst_n=0 SHALL immediately force: state IDLE, address 0, result 0, result_valid 0, fetch_req 0, wrap 0, counter 0.
REQ-026 Reset mid-FETCH or mid-HOLD SHALL discard the pending instruction; after release, the next fetch restarts at address 0.

Configuration
REQ-027 Macro FETCH_SEQ_JUMP_EN, when defined, SHALL add inputs jump_valid (1 bit) and jump_addr (ADDR_W bits).
REQ-028 With FETCH_SEQ_JUMP_EN defined, jump_valid SHALL be honoured only in IDLE or on a handshake cycle. There it SHALL load address with jump_addr, overriding the increment, with no wrap pulse; jump_addr >= PROG_LEN SHALL load 0.
REQ-029 With FETCH_SEQ_JUMP_EN defined, jump_valid in FETCH, or in HOLD without a handshake, SHALL be ignored.
REQ-030 Without FETCH_SEQ_JUMP_EN, the ports SHALL be absent and behaviour SHALL be purely sequential.

Structure
REQ-031 State encoding (IDLE=0, FETCH=1, HOLD=2) and the default parameter values SHALL live in shared package fetch_pkg.
REQ-032 The address advance/wrap/jump logic SHALL be one sub-module, fetch_addr_gen; the FSM, counter and result register stay in fetch_sequencer.

Verification
REQ-033 Defaults, en=1, result_ready=1, instruction=0xA5: first result_valid 5 cycles after en; result=0xA5; fetch_req high 4 cycles.
REQ-034 Defaults, 5 consecutive handshakes: address sequence 0,1,2,3,0; wrap pulses once, on the 3->0 step.
REQ-035 result_ready=0 for 10 cycles in HOLD while instruction changes: result unchanged; address unchanged; fetch_req=0.
REQ-036 en dropped on the 2nd FETCH cycle: fetch completes, result captured; after handshake, state IDLE and address=1.
REQ-037 rst_n pulsed low during FETCH at address 2: outputs zero asynchronously; after release with en=1, fetch_req asserts with address 0.
REQ-038 FETCH_SEQ_JUMP_EN, handshake with jump_valid=1 and jump_addr=3 at address 0: next address 3, no wrap; jump_addr=5 with ADDR_W=3, PROG_LEN=5: address 0.
